// File: rtl/cnu_msg_expand.sv
// cnu_msg_expand: check-node output stage of the min-sum LDPC decoder.
// Buffers compressed check-node records (min, min2, one-hot min index, input
// signs) in a 2-entry FIFO and expands each into D serialized c2v messages,
// one edge per cycle, in sign-magnitude form.
// Optional feature macro: CNU_OFFSET_EN (offset min-sum, saturating at 0).
module cnu_msg_expand #(
  parameter int unsigned data_w = 9,
  parameter int unsigned D      = 7,
  parameter int unsigned OFFSET = 1,
  localparam int unsigned edge_w = $clog2(D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_min,
  input  logic [data_w-1:0] in_min2,
  input  logic [D-1:0]      in_idx,
  input  logic [D-1:0]      in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [edge_w-1:0] out_edge,
  output logic              out_last
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

`ifdef CNU_OFFSET_EN
  localparam logic [data_w-1:0] off_c = data_w'(OFFSET);
`else
  // Offset disabled: a zero offset makes the saturating subtract a pass-through.
  localparam logic [data_w-1:0] off_c = data_w'(OFFSET * 0);
`endif

  state_t state_q, state_d;

  logic [data_w-1:0] min_mem  [2];
  logic [data_w-1:0] min2_mem [2];
  logic [D-1:0]      idx_mem  [2];
  logic [D-1:0]      sign_mem [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic [edge_w-1:0] cnt_q, cnt_d;
  logic              push, pop, load, out_free, cnt_last;
  logic [data_w-1:0] sel_mag, mag;
  logic              msg_sign;

  // Ready depends only on FIFO occupancy, never on in_valid.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign cnt_last = (cnt_q == edge_w'(D - 1));

  // Record storage; contents need no reset since count_q gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      min_mem[wr_ptr_q]  <= in_min;
      min2_mem[wr_ptr_q] <= in_min2;
      idx_mem[wr_ptr_q]  <= in_idx;
      sign_mem[wr_ptr_q] <= in_sign;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Emitter state and edge counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE loads edge 0 straight away so a fresh record shows up one cycle after its push.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != 2'd0) && out_free) begin
          load    = 1'b1;
          cnt_d   = cnt_q + edge_w'(1);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_free) begin
          load = 1'b1;
          if (cnt_last) begin
            pop   = 1'b1;
            cnt_d = '0;
            // Stay in EMIT when another record remains, counting a same-cycle push.
            if ((count_q == 2'd1) && !push) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + edge_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Message datapath for the head record at edge cnt_q.
  always_comb begin
    sel_mag  = idx_mem[rd_ptr_q][cnt_q] ? min2_mem[rd_ptr_q] : min_mem[rd_ptr_q];
    mag      = (sel_mag > off_c) ? (sel_mag - off_c) : '0;
    msg_sign = (^sign_mem[rd_ptr_q]) ^ sign_mem[rd_ptr_q][cnt_q];
  end

  // Output register: loads whenever free, holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_edge  <= '0;
      out_last  <= 1'b0;
    end else if (out_free) begin
      out_valid <= load;
      if (load) begin
        out_msg  <= {msg_sign, mag};
        out_edge <= cnt_q;
        out_last <= cnt_last;
      end
    end
  end

endmodule

// File: tb/tb_cnu_msg_expand.sv
// Testbench for cnu_msg_expand: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_cnu_msg_expand;

  localparam int unsigned DW  = 9;
  localparam int unsigned DD  = 7;
  localparam int unsigned EW  = 3;
  localparam int unsigned OFF = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_min, in_min2;
  logic [DD-1:0] in_idx, in_sign;
  logic          out_valid, out_ready;
  logic [DW:0]   out_msg;
  logic [EW-1:0] out_edge;
  logic          out_last;

  always #5 clk = ~clk;

  cnu_msg_expand #(.data_w(DW), .D(DD), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_min(in_min), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_edge(out_edge), .out_last(out_last)
  );

  typedef struct packed {
    logic [DW-1:0] mn;
    logic [DW-1:0] mn2;
    logic [DD-1:0] idx;
    logic [DD-1:0] sgn;
  } rec_t;

  rec_t          send_q[$];
  rec_t          fifo_q[$];
  logic [DW:0]   log_msg[$];
  logic [EW-1:0] log_edge[$];
  int            nxt;
  logic          m_valid;
  logic [DW:0]   m_msg;
  logic [EW-1:0] m_edge;
  logic          m_last;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            run_len, max_run, fired, pushed;
  int            rdy_mode;
  bit            gap_en;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int mn, input int mn2, input int idx, input int sgn);
    rec_t r;
    r.mn  = DW'(mn);
    r.mn2 = DW'(mn2);
    r.idx = DD'(idx);
    r.sgn = DD'(sgn);
    return r;
  endfunction

  // Expected message for edge e: magnitude from min/min2 selection, sign = parity of the others.
  function automatic logic [DW:0] exp_msg(input rec_t r, input int e);
    int mag;
    mag = r.idx[e] ? int'(r.mn2) : int'(r.mn);
`ifdef CNU_OFFSET_EN
    mag = mag - int'(OFF);
    if (mag < 0) mag = 0;
`endif
    return {(^r.sgn) ^ r.sgn[e], DW'(mag)};
  endfunction

  function automatic int exp_mag(input int sel);
`ifdef CNU_OFFSET_EN
    return (sel > int'(OFF)) ? sel - int'(OFF) : 0;
`else
    return sel;
`endif
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic tick();
    rec_t r;
    bit   free, psh;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    r = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    if (send_q.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      r = send_q[0];
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    in_min = r.mn; in_min2 = r.mn2; in_idx = r.idx; in_sign = r.sgn;
    #1;
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("in_ready", 32'(in_ready), 32'(fifo_q.size() < 2));
    if (m_valid) begin
      check_val("out_msg", 32'(out_msg), 32'(m_msg));
      check_val("out_edge", 32'(out_edge), 32'(m_edge));
      check_val("out_last", 32'(out_last), 32'(m_last));
    end
    if (out_valid) run_len++; else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (out_valid && out_ready) begin
      log_msg.push_back(out_msg);
      log_edge.push_back(out_edge);
    end
    free = !m_valid || out_ready;
    psh  = in_valid && (fifo_q.size() < 2);
    @(posedge clk);
    if (m_valid && out_ready) fired++;
    if (free) begin
      if (fifo_q.size() != 0) begin
        m_valid = 1'b1;
        m_msg   = exp_msg(fifo_q[0], nxt);
        m_edge  = EW'(nxt);
        m_last  = (nxt == int'(DD) - 1);
        nxt++;
        if (nxt == int'(DD)) begin
          nxt = 0;
          void'(fifo_q.pop_front());
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    if (psh) begin
      fifo_q.push_back(r);
      void'(send_q.pop_front());
      pushed++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((send_q.size() != 0 || fifo_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_val("drain_timeout", 32'(n), 32'(0));
  endtask

  task automatic clear_log();
    log_msg.delete();
    log_edge.delete();
  endtask

  initial begin
    int b_mag[7];
    int s1[7];
    int s2[7];
    int n;
    b_mag = '{3, 3, 5, 3, 3, 3, 3};
    s1    = '{0, 1, 1, 1, 1, 1, 1};
    s2    = '{1, 1, 0, 0, 0, 0, 0};
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_min = '0; in_min2 = '0; in_idx = '0; in_sign = '0;
    m_valid = 1'b0; m_msg = '0; m_edge = '0; m_last = 1'b0; nxt = 0;
    rdy_mode = 0; gap_en = 1'b0; run_len = 0; max_run = 0; fired = 0; pushed = 0;
    #2;
    check_val("rst_out_valid", 32'(out_valid), 32'(0));
    check_val("rst_in_ready", 32'(in_ready), 32'(1));
    check_val("rst_out_msg", 32'(out_msg), 32'(0));
    check_val("rst_out_edge", 32'(out_edge), 32'(0));
    check_val("rst_out_last", 32'(out_last), 32'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Basic expansion with first-message latency.
    clear_log();
    send_q.push_back(mk(3, 5, 7'b0000100, 0));
    tick();
    tick();
    check_val("first_latency", 32'(out_valid), 32'(1));
    check_val("first_edge", 32'(out_edge), 32'(0));
    drain(50);
    check_val("basic_count", 32'(log_msg.size()), 32'(7));
    for (int i = 0; i < 7 && i < log_msg.size(); i++) begin
      check_val("basic_mag", 32'(log_msg[i][DW-1:0]), 32'(exp_mag(b_mag[i])));
      check_val("basic_sign", 32'(log_msg[i][DW]), 32'(0));
      check_val("basic_edge", 32'(log_edge[i]), 32'(i));
    end

    // Sign rule: parity of all other edges.
    clear_log();
    send_q.push_back(mk(4, 6, 0, 7'b0000001));
    send_q.push_back(mk(4, 6, 0, 7'b0000011));
    drain(60);
    check_val("sign_count", 32'(log_msg.size()), 32'(14));
    for (int i = 0; i < 7 && i + 7 < log_msg.size(); i++) begin
      check_val("sign_par1", 32'(log_msg[i][DW]), 32'(s1[i]));
      check_val("sign_par0", 32'(log_msg[i+7][DW]), 32'(s2[i]));
    end

    // Back-to-back: three records, no bubble.
    clear_log();
    max_run = 0; run_len = 0;
    for (int i = 0; i < 3; i++) send_q.push_back(mk(10 + i, 20 + i, 1 << i, i));
    drain(80);
    check_val("b2b_run", 32'(max_run), 32'(21));
    check_val("b2b_count", 32'(log_msg.size()), 32'(21));
    for (int i = 0; i < log_edge.size(); i++)
      check_val("b2b_edge_order", 32'(log_edge[i]), 32'(i % 7));

    // Backpressure pattern 1,0,0 repeating.
    rdy_mode = 1; fired = 0; pushed = 0;
    for (int i = 0; i < 4; i++) send_q.push_back(mk(7 * i, 3 + i, 1 << (i + 2), 5 * i));
    drain(300);
    check_val("bp_fired", 32'(fired), 32'(pushed * int'(DD)));

    // Reset mid-record while edge 3 is presented.
    rdy_mode = 0;
    send_q.push_back(mk(8, 9, 7'b0001000, 7'b1010101));
    n = 0;
    while (!(m_valid && m_edge == 3) && n < 30) begin
      tick();
      n++;
    end
    check_val("reach_edge3", 32'(n < 30), 32'(1));
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'(0));
    check_val("arst_in_ready", 32'(in_ready), 32'(1));
    check_val("arst_out_edge", 32'(out_edge), 32'(0));
    check_val("arst_out_last", 32'(out_last), 32'(0));
    check_val("arst_out_msg", 32'(out_msg), 32'(0));
    fifo_q.delete(); send_q.delete();
    m_valid = 1'b0; m_msg = '0; m_edge = '0; m_last = 1'b0; nxt = 0;
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    send_q.push_back(mk(2, 11, 7'b0100000, 7'b0000110));
    drain(50);
    check_val("post_rst_count", 32'(log_msg.size()), 32'(7));
    if (log_edge.size() != 0) check_val("post_rst_edge0", 32'(log_edge[0]), 32'(0));

    // Offset saturation case.
    clear_log();
    send_q.push_back(mk(0, 5, 7'b1000000, 0));
    drain(50);
    check_val("off_count", 32'(log_msg.size()), 32'(7));
    for (int i = 0; i < 7 && i < log_msg.size(); i++)
      check_val("off_mag", 32'(log_msg[i][DW-1:0]), 32'(exp_mag(i == 6 ? 5 : 0)));

    // Randomized traffic with gaps, random backpressure and arbitrary idx patterns.
    rdy_mode = 2; gap_en = 1'b1; fired = 0; pushed = 0;
    for (int i = 0; i < 40; i++)
      send_q.push_back(mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom)));
    drain(3000);
    check_val("rand_fired", 32'(fired), 32'(pushed * int'(DD)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnu_msg_expand.md
Name: cnu_msg_expand

Overview:
- Check-node output stage of the LDPC min-sum decoder; the consumer of the compressed check-node state (min, min2, one-hot min index) produced by the CNU comparator tree.
- Buffers compressed records (min, min2, min_idx, per-edge input signs) and expands each one into D serialized check-to-variable messages, one edge per cycle.
- Uses a valid/ready handshake on both sides and feeds the VNU message router.

Parameters:
- data_w, 9, magnitude width of min/min2 and of the message magnitude.
- D, 7, check-node degree, i.e. messages per record; legal range 2..8.
- OFFSET, 1, offset subtracted from the magnitude; used only when CNU_OFFSET_EN is defined.
- localparam edge_w = $clog2(D), width of the edge index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  compressed record present.
- in_ready  out  1  record buffer can accept.
- in_min  in  data_w  smallest magnitude.
- in_min2  in  data_w  second-smallest magnitude.
- in_idx  in  D  one-hot position of min.
- in_sign  in  D  sign bits of the incoming v2c messages; 1 = negative.
- out_valid  out  1  message valid.
- out_ready  in  1  downstream accepts.
- out_msg  out  data_w+1  {sign, magnitude} sign-magnitude message.
- out_edge  out  edge_w  edge number 0..D-1.
- out_last  out  1  set on edge D-1 of each record.

Behaviour:
- Record buffer
  - 2-entry FIFO; each entry is 2*data_w+2*D bits.
  - in_ready = !full, combinational from the FIFO count only; it does not depend on in_valid.
  - A push happens when in_valid && in_ready.
- Emitter
  - Two states, IDLE and EMIT, plus an edge counter cnt (edge_w bits).
  - IDLE->EMIT when the FIFO is non-empty and the output register is free (out_valid==0 || out_ready).
  - In EMIT, on every cycle the output register is free, load:
    - out_edge = cnt
    - out_msg magnitude = in_idx[cnt] ? min2 : min
    - out_msg sign = (^sign) ^ sign[cnt]
    - out_last = (cnt == D-1)
    - then cnt increments.
  - On loading edge D-1: pop the FIFO and reset cnt to 0.
    - If the FIFO still holds a record after the pop (including a same-cycle push into an otherwise empty slot), stay in EMIT with no bubble.
    - Otherwise go to IDLE.
- Latency and throughput
  - A record pushed at cycle t produces its edge-0 message with out_valid high at t+1 when the FIFO was empty and the output was idle.
  - Sustained throughput is D messages per D cycles.
- Stall
  - While out_valid && !out_ready, out_msg, out_edge, out_last and cnt hold.
  - The FIFO may still accept input until it is full.
- Simultaneous push and pop in the same cycle: both occur, and the count is unchanged.
- Malformed in_idx
  - All zero: every edge uses min.
  - Multiple bits set: every flagged edge uses min2.
  - Neither case is flagged as an error.
- Reset
  - Asserting rst at any time, including mid-record, immediately clears FIFO, cnt, state=IDLE, out_valid=0, out_msg=0, out_edge=0, out_last=0.
  - Partial records are discarded; in_ready=1 after reset.

Optional Feature:
- Macro: CNU_OFFSET_EN.
- Defined: magnitude = max(selected - OFFSET, 0); saturates at 0 and never wraps. The subtraction is in the output-register load path, so latency is unchanged.
- Undefined: magnitude = selected min/min2 unmodified, and OFFSET is ignored.

Test Plan:
- Basic expansion: D=7, push min=3, min2=5, idx=7'b0000100, sign=0. Required: 7 messages, edges 0..6, magnitudes 3,3,5,3,3,3,3, all signs 0, out_last only on edge 6, first out_valid one cycle after the push.
- Sign rule: sign=7'b0000001 (parity 1). Required: edge 0 sign 0, edges 1..6 sign 1. Then sign=7'b0000011 (parity 0). Required: edges 0,1 sign 1, edges 2..6 sign 0.
- Back-to-back: out_ready held 1, three records pushed on consecutive cycles. Required: in_ready drops after the second record is pushed and rises when the first record's edge 6 loads; 21 consecutive valid cycles with no bubble; edge order 0..6 repeated three times.
- Backpressure: out_ready toggled 1,0,0,1,... Required: out_msg, out_edge and out_last stable while stalled; no edge skipped or duplicated; record count preserved.
- Reset mid-record: assert rst while edge 3 is presented. Required: out_valid=0 asynchronously and FIFO empty. After release, a new record emits from edge 0 and no residual messages appear.
- CNU_OFFSET_EN with OFFSET=1: min=0, min2=5, idx=7'b1000000. Required: magnitudes 0 (saturated) for edges 0..5 and 4 for edge 6.
